systolic_engine: RTL and testbench

//  Self-sequenced, parametrised output-stationary systolic matrix engine: C[DIM][DIM] = sum_k A[:,k]*B[k,:].

---
 rtl/sa_pkg.sv | 34 +++
 rtl/sa_pe.sv | 73 +++++++
 rtl/systolic_engine.sv | 177 +++++++++++++++++
 tb/tb_systolic_engine.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic matrix engine.
package sa_pkg;

   // Job sequencing states
   typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

   // Accumulate result: the value to store and whether it hit a limit
   typedef struct packed {
      logic signed [63:0] sum;
      logic               ovf;
   } sat_res_t;

   // Index width for a count of n items (never zero-width)
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Add two sign-extended values and clamp to the w-bit signed range.
   // The caller decides whether to use the clamped value or the raw wrap.
   function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                        input logic signed [63:0] b,
                                        input int w);
      sat_res_t           r;
      logic signed [63:0] s, lim, hi, lo;
      s     = a + b;
      lim   = 64'sd1 <<< (w - 1);
      hi    = lim - 64'sd1;
      lo    = -lim;
      r.ovf = (s > hi) || (s < lo);
      r.sum = (s > hi) ? hi : ((s < lo) ? lo : s);
      return r;
   endfunction

endpackage

// File: rtl/sa_pe.sv
// One processing element: registered a/b pass-through plus a MAC accumulator.
module sa_pe
   import sa_pkg::*;
#(
   parameter int BITS     = 8,
   parameter int ACC_BITS = 32,
   parameter int SAT      = 0
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       en,
   input  logic signed [BITS-1:0]     a_in,
   input  logic signed [BITS-1:0]     b_in,
   output logic [BITS-1:0]            a_out,
   output logic [BITS-1:0]            b_out,
   output logic [ACC_BITS-1:0]        acc
);
   localparam int PW = 2 * BITS;

   logic [BITS-1:0]            a_q, a_d, b_q, b_d;
   logic signed [ACC_BITS-1:0] acc_q, acc_d;
   logic                       sat_q, sat_d;
   logic signed [PW-1:0]       prod;
   sat_res_t                   res;

   assign prod  = PW'(a_in) * PW'(b_in);
   assign res   = sat_add(64'(acc_q), 64'(prod), ACC_BITS);
   assign a_out = a_q;
   assign b_out = b_q;
   assign acc   = acc_q;

   // Next state: clear wins; otherwise advance operands and accumulate when enabled.
   // With saturation on, an accumulator that hit a limit stays there until cleared.
   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      acc_d = acc_q;
      sat_d = sat_q;
      if (clr) begin
         a_d   = '0;
         b_d   = '0;
         acc_d = '0;
         sat_d = 1'b0;
      end else if (en) begin
         a_d = a_in;
         b_d = b_in;
         if (SAT != 0) begin
            if (!sat_q) begin
               acc_d = ACC_BITS'(res.sum);
               sat_d = res.ovf;
            end
         end else begin
            acc_d = acc_q + ACC_BITS'(prod);
         end
      end
   end

   // PE state registers
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
         sat_q <= 1'b0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         acc_q <= acc_d;
         sat_q <= sat_d;
      end

endmodule

// File: rtl/systolic_engine.sv
// Output-stationary DIM x DIM systolic engine: skewed operand injection,
// job FSM (IDLE/LOAD/FLUSH/DRAIN) and a row-serial result drain.
module systolic_engine
   import sa_pkg::*;
#(
   parameter int BITS     = 8,
   parameter int DIM      = 8,
   parameter int ACC_BITS = 32,
   parameter int KW       = 16,
   parameter int SAT      = 0
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [KW-1:0]                 k_len,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DIM-1:0][BITS-1:0]      A,
   input  logic [DIM-1:0][BITS-1:0]      B,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [idx_w(DIM)-1:0]         out_row,
   output logic [DIM-1:0][ACC_BITS-1:0]  Cout,
   output logic                          busy,
   output logic                          done
);
   localparam int RW = idx_w(DIM);
   localparam int FW = idx_w(2 * DIM);

   state_t          state_q, state_d;
   logic [KW-1:0]   k_q, k_d, beat_q, beat_d;
   logic [FW-1:0]   fl_q, fl_d;
   logic [RW-1:0]   row_q, row_d;
   logic            done_q, done_d;
   logic            clr, en, inject;

   logic [DIM-1:0][BITS-1:0]            a_lane, b_lane, a_sk, b_sk;
   logic [DIM-1:0][DIM:0][BITS-1:0]     a_h;
   logic [DIM:0][DIM-1:0][BITS-1:0]     b_v;
   logic [DIM-1:0][DIM-1:0][ACC_BITS-1:0] acc_arr;

   // Bubble cycles (no accepted beat) feed zeros so the array never stalls
   assign a_lane = inject ? A : '0;
   assign b_lane = inject ? B : '0;

   // Lane i is delayed i cycles so row/column data meets on the anti-diagonal
   for (genvar i = 0; i < DIM; i++) begin : g_skew
      if (i == 0) begin : g_direct
         assign a_sk[i] = a_lane[i];
         assign b_sk[i] = b_lane[i];
      end else begin : g_dly
         logic [i-1:0][BITS-1:0] sa_q, sa_d, sb_q, sb_d;
         // Shift the lane delay line while the array advances
         always_comb begin
            sa_d = sa_q;
            sb_d = sb_q;
            if (clr) begin
               sa_d = '0;
               sb_d = '0;
            end else if (en) begin
               for (int s = i - 1; s > 0; s--) begin
                  sa_d[s] = sa_q[s-1];
                  sb_d[s] = sb_q[s-1];
               end
               sa_d[0] = a_lane[i];
               sb_d[0] = b_lane[i];
            end
         end
         // Delay line registers
         always_ff @(posedge clk or posedge rst)
            if (rst) begin
               sa_q <= '0;
               sb_q <= '0;
            end else begin
               sa_q <= sa_d;
               sb_q <= sb_d;
            end
         assign a_sk[i] = sa_q[i-1];
         assign b_sk[i] = sb_q[i-1];
      end
      assign a_h[i][0] = a_sk[i];
      assign b_v[0][i] = b_sk[i];
   end

   // A flows right along rows, B flows down columns
   for (genvar i = 0; i < DIM; i++) begin : g_row
      for (genvar j = 0; j < DIM; j++) begin : g_col
         sa_pe #(.BITS(BITS), .ACC_BITS(ACC_BITS), .SAT(SAT)) u_pe (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr),
            .en    (en),
            .a_in  (a_h[i][j]),
            .b_in  (b_v[i][j]),
            .a_out (a_h[i][j+1]),
            .b_out (b_v[i+1][j]),
            .acc   (acc_arr[i][j])
         );
      end
   end

   // Job FSM, beat/flush/row counters and handshake outputs
   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      beat_d    = beat_q;
      fl_d      = fl_q;
      row_d     = row_q;
      done_d    = 1'b0;
      clr       = 1'b0;
      en        = 1'b0;
      inject    = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            k_d     = k_len;
            beat_d  = '0;
            fl_d    = '0;
            row_d   = '0;
            clr     = 1'b1;
            state_d = (k_len == '0) ? DRAIN : LOAD;
         end
         LOAD: begin
            in_ready = 1'b1;
            en       = 1'b1;
            if (in_valid) begin
               inject = 1'b1;
               beat_d = beat_q + KW'(1);
               if (beat_d == k_q) state_d = FLUSH;
            end
         end
         FLUSH: begin
            // Enough cycles for the last beat to reach the far corner PE
            en   = 1'b1;
            fl_d = fl_q + FW'(1);
            if (fl_q == FW'(2 * DIM - 2)) state_d = DRAIN;
         end
         DRAIN: begin
            out_valid = 1'b1;
            if (out_ready) begin
               row_d = row_q + RW'(1);
               if (row_q == RW'(DIM - 1)) begin
                  row_d   = '0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control registers
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         k_q     <= '0;
         beat_q  <= '0;
         fl_q    <= '0;
         row_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         beat_q  <= beat_d;
         fl_q    <= fl_d;
         row_q   <= row_d;
         done_q  <= done_d;
      end

   assign busy    = (state_q != IDLE);
   assign done    = done_q;
   assign out_row = row_q;
   assign Cout    = (state_q == DRAIN) ? acc_arr[row_q] : '0;

endmodule

// File: tb/tb_systolic_engine.sv
// Scoreboard bench: three engines (32-bit wrap, 16-bit sat, 16-bit wrap) share
// one stimulus stream; each has its own expected-row queue and monitor.
module tb_systolic_engine;

   typedef struct packed {
      logic [31:0]      row;
      logic [3:0][31:0] v;
   } exp_t;

   logic             clk, rst, start, in_valid, out_ready;
   logic [15:0]      k_len;
   logic [3:0][7:0]  a_in, b_in;
   logic [2:0]       rdy, ov, bsy, dn;
   logic [1:0]       row0, row1, row2;
   logic [3:0][31:0] c0;
   logic [3:0][15:0] c1, c2;

   exp_t q0[$], q1[$], q2[$];
   int   checks = 0, fails = 0, done_cnt = 0;
   int   am[4][4], bm[4][4];

   systolic_engine #(.BITS(8), .DIM(4), .ACC_BITS(32), .KW(16), .SAT(0)) u_w32 (
      .clk(clk), .rst(rst), .start(start), .k_len(k_len), .in_valid(in_valid), .in_ready(rdy[0]),
      .A(a_in), .B(b_in), .out_valid(ov[0]), .out_ready(out_ready), .out_row(row0), .Cout(c0),
      .busy(bsy[0]), .done(dn[0]));
   systolic_engine #(.BITS(8), .DIM(4), .ACC_BITS(16), .KW(16), .SAT(1)) u_s16 (
      .clk(clk), .rst(rst), .start(start), .k_len(k_len), .in_valid(in_valid), .in_ready(rdy[1]),
      .A(a_in), .B(b_in), .out_valid(ov[1]), .out_ready(out_ready), .out_row(row1), .Cout(c1),
      .busy(bsy[1]), .done(dn[1]));
   systolic_engine #(.BITS(8), .DIM(4), .ACC_BITS(16), .KW(16), .SAT(0)) u_w16 (
      .clk(clk), .rst(rst), .start(start), .k_len(k_len), .in_valid(in_valid), .in_ready(rdy[2]),
      .A(a_in), .B(b_in), .out_valid(ov[2]), .out_ready(out_ready), .out_row(row2), .Cout(c2),
      .busy(bsy[2]), .done(dn[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0][31:0] ext16(input logic [3:0][15:0] v);
      logic [3:0][31:0] r;
      for (int j = 0; j < 4; j++) r[j] = 32'(signed'(v[j]));
      return r;
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s got=%0d need=%0d", name, got, exp);
      end
   endtask

   task automatic chk_vec(input string name, input logic [3:0][31:0] got, input logic [3:0][31:0] exp);
      checks++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s got=%0d,%0d,%0d,%0d need=%0d,%0d,%0d,%0d", name,
                  $signed(got[0]), $signed(got[1]), $signed(got[2]), $signed(got[3]),
                  $signed(exp[0]), $signed(exp[1]), $signed(exp[2]), $signed(exp[3]));
      end
   endtask

   // Pop the next expected row of engine id and compare it against what is on the bus
   task automatic cmp_row(input int id, input logic [1:0] row, input logic [3:0][31:0] got);
      exp_t e;
      if (id == 0 && q0.size() > 0)      e = q0.pop_front();
      else if (id == 1 && q1.size() > 0) e = q1.pop_front();
      else if (id == 2 && q2.size() > 0) e = q2.pop_front();
      else begin
         checks++;
         fails++;
         $display("FAIL unexpected_row dut%0d got row=%0d need none", id, row);
         return;
      end
      chk($sformatf("row_index_dut%0d", id), int'(row), int'(e.row));
      chk_vec($sformatf("row_data_dut%0d_row%0d", id, e.row), got, e.v);
   endtask

   // Monitor: every accepted result row is scored against the queues
   always @(negedge clk) begin
      if (!rst) begin
         if (out_ready && ov[0]) cmp_row(0, row0, c0);
         if (out_ready && ov[1]) cmp_row(1, row1, ext16(c1));
         if (out_ready && ov[2]) cmp_row(2, row2, ext16(c2));
         if (dn[0]) done_cnt++;
      end
   end

   task automatic set_ident();
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            am[i][j] = (i == j) ? 1 : 0;
            bm[i][j] = i * 4 + j + 1;
         end
   endtask

   task automatic set_fill(input int av, input int bv);
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            am[i][j] = av;
            bm[i][j] = bv;
         end
   endtask

   task automatic push_b_rows();
      exp_t e;
      for (int r = 0; r < 4; r++) begin
         e.row = 32'(r);
         for (int j = 0; j < 4; j++) e.v[j] = 32'(bm[r][j]);
         q0.push_back(e); q1.push_back(e); q2.push_back(e);
      end
   endtask

   task automatic push_const(input int v0, input int v1, input int v2);
      exp_t e;
      for (int r = 0; r < 4; r++) begin
         e.row = 32'(r);
         for (int j = 0; j < 4; j++) e.v[j] = 32'(v0);
         q0.push_back(e);
         for (int j = 0; j < 4; j++) e.v[j] = 32'(v1);
         q1.push_back(e);
         for (int j = 0; j < 4; j++) e.v[j] = 32'(v2);
         q2.push_back(e);
      end
   endtask

   task automatic start_job(input int k);
      @(posedge clk); #1;
      start = 1'b1;
      k_len = 16'(k);
      @(posedge clk); #1;
      start = 1'b0;
      k_len = '0;
   endtask

   // Stream k beats (A column n, B row n); optional bubbles and a stray start in LOAD
   task automatic feed(input int k, input bit bub, input bit poke);
      int n = 0;
      int cyc = 0;
      bit acc;
      while (n < k && cyc < 100) begin
         in_valid = bub ? ((cyc % 2) == 0) : 1'b1;
         for (int i = 0; i < 4; i++) begin
            a_in[i] = 8'(am[i][n]);
            b_in[i] = 8'(bm[n][i]);
         end
         if (poke && n == 0) begin
            start = 1'b1;
            k_len = 16'd9;
         end
         @(negedge clk);
         acc = in_valid && rdy[0];
         @(posedge clk); #1;
         start = 1'b0;
         k_len = '0;
         if (acc) n++;
         cyc++;
      end
      in_valid = 1'b0;
      a_in     = '0;
      b_in     = '0;
      chk("beats_accepted", n, k);
      @(negedge clk);
      chk("in_ready_after_last_beat", int'(rdy[0]), 0);
   endtask

   task automatic wait_done(input string name);
      int cyc = 0;
      bit seen = 1'b0;
      while (!seen && cyc < 200) begin
         @(negedge clk);
         if (dn[0]) seen = 1'b1;
         cyc++;
      end
      chk({name, "_done_seen"}, int'(seen), 1);
      chk({name, "_idle_at_done"}, int'(bsy[0]), 0);
      chk({name, "_rows_left"}, q0.size() + q1.size() + q2.size(), 0);
      @(negedge clk);
      chk({name, "_done_one_cycle"}, int'(dn[0]), 0);
   endtask

   initial begin
      logic [3:0][31:0] er2;
      int cyc;
      rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0; out_ready = 1'b1;
      a_in = '0; b_in = '0;

      // Reset state
      @(negedge clk);
      chk("rst_in_ready", int'(rdy[0]), 0);
      chk("rst_out_valid", int'(ov[0]), 0);
      chk("rst_busy", int'(bsy[0]), 0);
      chk("rst_done", int'(dn[0]), 0);
      chk("rst_out_row", int'(row0), 0);
      chk_vec("rst_cout", c0, '0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Identity, continuous beats
      set_ident(); push_b_rows();
      start_job(4); feed(4, 1'b0, 1'b0); wait_done("ident");

      // Identity with a bubble every other cycle
      push_b_rows();
      start_job(4); feed(4, 1'b1, 1'b0); wait_done("bubble");

      // 127*127 x4: 64516 exact, 32767 saturated, -1020 wrapped at 16 bits
      set_fill(127, 127); push_const(64516, 32767, -1020);
      start_job(4); feed(4, 1'b0, 1'b0); wait_done("overflow");

      // (-128)*(-128) x2 with a stray start during LOAD
      set_fill(-128, -128); push_const(32768, 32767, -32768);
      start_job(2); feed(2, 1'b0, 1'b1); wait_done("neg_neg");

      // -3*5 single beat
      set_fill(-3, 5); push_const(-15, -15, -15);
      start_job(1); feed(1, 1'b0, 1'b0); wait_done("neg_pos");

      // Empty job drains four zero rows
      push_const(0, 0, 0);
      start_job(0); wait_done("k_zero");

      // Identity with out_ready held low while row 2 is presented
      set_ident(); push_b_rows();
      for (int j = 0; j < 4; j++) er2[j] = 32'(bm[2][j]);
      start_job(4); feed(4, 1'b0, 1'b0);
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!(ov[0] && row0 == 2'd2) && cyc < 100);
      chk("bp_reached_row2", int'(cyc < 100), 1);
      out_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("bp_out_valid", int'(ov[0]), 1);
         chk("bp_out_row", int'(row0), 2);
         chk_vec("bp_cout", c0, er2);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_done("backpressure");

      // Reset during FLUSH discards the job
      start_job(4); feed(4, 1'b0, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("midrst_busy", int'(bsy[0]), 0);
      chk("midrst_out_valid", int'(ov[0]), 0);
      chk("midrst_in_ready", int'(rdy[0]), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Clean rerun after the abort
      push_b_rows();
      start_job(4); feed(4, 1'b0, 1'b0); wait_done("rerun");

      chk("done_pulses", done_cnt, 8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
